// File: rtl/instruction_fetch_if.sv
// Fetch-side bundle: instruction memory request/response, redirect input and the decode hand-off.
// Handshakes: a transfer occurs in a cycle where valid and ready are both 1; the valid side holds its payload until then.
interface instruction_fetch_if;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic [31:0] if_instruction;
   logic [31:0] if_pc;
   logic        if_ready;
   logic        misalign_fault;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid, imem_rsp_data,
      input  redirect_valid, redirect_pc,
      output if_valid, if_instruction, if_pc,
      input  if_ready,
      output misalign_fault
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid, imem_rsp_data,
      output redirect_valid, redirect_pc,
      input  if_valid, if_instruction, if_pc,
      output if_ready,
      input  misalign_fault
   );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: sequential word fetches, in-order responses buffered in a 2-entry FIFO, redirect flush.
// Define IF_MISALIGN_TRAP_EN to trap misaligned redirect targets instead of forcing them word aligned.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input logic                 clk,
   input logic                 rst,
   instruction_fetch_if.master bus
);
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t      buf_q [2];
   entry_t      buf_d [2];
   logic        head_q, head_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [1:0]  out_q, out_d;
   logic [3:0]  drop_q, drop_d;
   logic [31:0] pc_q, pc_d;
   logic        fault_q, fault_d;

   logic [31:0] tgt_pc;
   logic        tgt_bad;
   logic [2:0]  in_use;
   logic [3:0]  in_mem;
   logic        req_fire, pop, rsp_stale, push, wr_idx;
   logic [31:0] rsp_pc;

   always_comb begin
`ifdef IF_MISALIGN_TRAP_EN
      tgt_pc  = bus.redirect_pc;
      tgt_bad = |bus.redirect_pc[1:0];
`else
      tgt_pc  = bus.redirect_pc & 32'hFFFF_FFFC;
      tgt_bad = 1'b0;
`endif
   end

   // out_q counts only live requests; stale ones in flight live in drop_q.
   assign in_use    = {1'b0, out_q} + {1'b0, cnt_q};
   assign in_mem    = drop_q + {2'b00, out_q};
   assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
   assign pop       = bus.if_valid && bus.if_ready;
   assign rsp_stale = (drop_q != 4'd0);
   assign push      = bus.imem_rsp_valid && !rsp_stale && (out_q != 2'd0);
   // Live requests are contiguous, so the oldest one sits out_q words behind the next fetch PC.
   assign rsp_pc    = pc_q - {28'd0, out_q, 2'b00};
   assign wr_idx    = head_q ^ cnt_q[0];

   assign bus.imem_req_valid = !rst && !bus.redirect_valid && !fault_q && (in_use < 3'(BUF_DEPTH));
   assign bus.imem_req_addr  = pc_q;
   assign bus.if_valid       = !rst && (cnt_q != 2'd0);
   assign bus.if_instruction = buf_q[head_q].instr;
   assign bus.if_pc          = buf_q[head_q].pc;
`ifdef IF_MISALIGN_TRAP_EN
   assign bus.misalign_fault = fault_q;
`else
   assign bus.misalign_fault = 1'b0;
`endif

   always_comb begin
      buf_d   = buf_q;
      head_d  = head_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      drop_d  = drop_q;
      pc_d    = pc_q;
      fault_d = fault_q;
      if (bus.redirect_valid) begin
         head_d  = 1'b0;
         cnt_d   = 2'd0;
         out_d   = 2'd0;
         pc_d    = tgt_pc;
         fault_d = tgt_bad;
         // A response arriving this cycle is already discarded by the flush.
         drop_d  = (bus.imem_rsp_valid && (in_mem != 4'd0)) ? in_mem - 4'd1 : in_mem;
      end else begin
         if (req_fire) begin
            pc_d = pc_q + 32'd4;
         end
         if (bus.imem_rsp_valid && rsp_stale) begin
            drop_d = drop_q - 4'd1;
         end
         if (push) begin
            buf_d[wr_idx] = {rsp_pc, bus.imem_rsp_data};
         end
         out_d = out_q + {1'b0, req_fire} - {1'b0, push};
         cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
         if (pop) begin
            head_d = ~head_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= 1'b0;
         cnt_q   <= 2'd0;
         out_q   <= 2'd0;
         drop_q  <= 4'd0;
         pc_q    <= RESET_PC;
         fault_q <= 1'b0;
      end else begin
         head_q  <= head_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         drop_q  <= drop_d;
         pc_q    <= pc_d;
         fault_q <= fault_d;
      end
      buf_q <= buf_d;
   end
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized traffic, checked every cycle against a
// queue model of sequential fetch, an in-order memory with epoch-tagged requests and a 2-entry decode buffer.
module tb_instruction_fetch;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   typedef struct {
      logic [31:0] addr;
      int          epoch;
      int          due;
   } mem_item_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   instruction_fetch_if bus ();

   instruction_fetch #(.RESET_PC(RESET_PC), .BUF_DEPTH(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Model state: PCs expected at decode (oldest first) and requests held by the memory.
   logic [31:0] exp_q[$];
   mem_item_t   mem_q[$];
   int          epoch = 0;
   logic [31:0] next_pc = RESET_PC;
   logic        fault_m = 1'b0;
   int          min_delay = 0;
   int          max_delay = 0;

   bit          log_on = 1'b0;
   logic [31:0] acc_log[$];
   int          first_acc = -1;
   int          first_ifv = -1;
   logic [31:0] first_ifv_pc = 32'hFFFF_FFFF;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : model
      int        inflight;
      logic      exp_rv;
      logic      exp_iv;
      bit        got_rsp;
      mem_item_t rsp;
      inflight = 0;
      foreach (mem_q[i]) if (mem_q[i].epoch == epoch) inflight++;
      exp_rv = !rst && !bus.redirect_valid && !fault_m && ((inflight + exp_q.size()) < 2);
      exp_iv = !rst && (exp_q.size() != 0);
      check("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
      if (exp_rv) check("req_addr", bus.imem_req_addr, next_pc);
      check("if_valid", 32'(bus.if_valid), 32'(exp_iv));
      if (exp_iv) begin
         check("if_pc", bus.if_pc, exp_q[0]);
         check("if_instruction", bus.if_instruction, mem_word(exp_q[0]));
      end
      check("misalign_fault", 32'(bus.misalign_fault), 32'(fault_m));

      if (log_on) begin
         if (bus.imem_req_valid && bus.imem_req_ready) begin
            acc_log.push_back(bus.imem_req_addr);
            if (first_acc < 0) first_acc = cyc;
         end
         if (bus.if_valid && first_ifv < 0) begin
            first_ifv    = cyc;
            first_ifv_pc = bus.if_pc;
         end
      end

      got_rsp = 1'b0;
      if (bus.imem_rsp_valid && mem_q.size() != 0) begin
         rsp     = mem_q.pop_front();
         got_rsp = 1'b1;
      end
      if (rst) begin
         exp_q.delete();
         epoch++;
         next_pc = RESET_PC;
         fault_m = 1'b0;
      end else if (bus.redirect_valid) begin
         exp_q.delete();
         epoch++;
`ifdef IF_MISALIGN_TRAP_EN
         next_pc = bus.redirect_pc;
         fault_m = (bus.redirect_pc[1:0] != 2'b00);
`else
         next_pc = {bus.redirect_pc[31:2], 2'b00};
`endif
      end else begin
         if (exp_q.size() != 0 && bus.if_ready) void'(exp_q.pop_front());
         if (got_rsp && rsp.epoch == epoch) exp_q.push_back(rsp.addr);
         if (exp_rv && bus.imem_req_ready) begin
            mem_q.push_back('{next_pc, epoch, cyc + 1 + int'($urandom_range(max_delay, min_delay))});
            next_pc = next_pc + 32'd4;
         end
      end
   end

   task automatic drive(input logic r, input logic redir, input logic [31:0] rpc,
                        input logic rdy, input logic ifr);
      @(posedge clk);
      #1;
      rst                = r;
      bus.redirect_valid = redir;
      bus.redirect_pc    = rpc;
      bus.imem_req_ready = rdy;
      bus.if_ready       = ifr;
      if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = mem_word(mem_q[0].addr);
      end else begin
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data  = $urandom;
      end
   endtask

   task automatic do_reset(input int n);
      repeat (n) drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [31:0] held;
      logic [31:0] rpc;
      bit          got;
      bit          redir;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'd0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'd0;
      bus.if_ready       = 1'b0;

      // Reset release, zero-wait memory, decode always ready.
      do_reset(3);
      log_on = 1'b1;
      repeat (8) drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      @(negedge clk);
      #1;
      log_on = 1'b0;
      for (int i = 0; i < 3; i++)
         check("boot_addr", (i < acc_log.size()) ? acc_log[i] : 32'hDEAD_DEAD, 32'(4 * i));
      check("boot_latency", 32'(first_ifv - first_acc), 32'd2);
      check("boot_if_pc", first_ifv_pc, 32'h0000_0000);

      // Decode stalled for 5 cycles: buffer fills with PC 0x0 and 0x4.
      do_reset(10);
      repeat (3) drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
      @(negedge clk);
      held = bus.if_instruction;
      repeat (2) drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
      @(negedge clk);
      check("hold_if_valid", 32'(bus.if_valid), 32'd1);
      check("hold_if_pc", bus.if_pc, 32'h0000_0000);
      check("hold_instr_stable", bus.if_instruction, held);
      check("hold_instr", bus.if_instruction, mem_word(32'h0000_0000));
      check("hold_no_req", 32'(bus.imem_req_valid), 32'd0);
      drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
      @(negedge clk);
      check("hold_next_pc", bus.if_pc, 32'h0000_0004);

      // Memory not ready for 3 cycles: address held at 0x8.
      do_reset(10);
      repeat (2) drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
         @(negedge clk);
         check("stall_addr", bus.imem_req_addr, 32'h0000_0008);
      end
      check("stall_req_valid", 32'(bus.imem_req_valid), 32'd1);
      repeat (3) drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      @(negedge clk);
      check("stall_if_pc", bus.if_pc, 32'h0000_0008);

      // Redirect to 0x100 with one request outstanding.
      do_reset(10);
      min_delay = 2;
      max_delay = 2;
      drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      @(negedge clk);
      check("redir_req_valid", 32'(bus.imem_req_valid), 32'd1);
      check("redir_req_addr", bus.imem_req_addr, 32'h0000_0100);
      #1;
      min_delay = 0;
      max_delay = 0;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
         @(negedge clk);
         if (bus.if_valid) begin
            got = 1'b1;
            check("redir_if_pc", bus.if_pc, 32'h0000_0100);
         end
      end
      check("redir_timeout", 32'(got), 32'd1);

`ifdef IF_MISALIGN_TRAP_EN
      do_reset(10);
      drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 32'h0000_0102, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
         @(negedge clk);
         check("mis_fault", 32'(bus.misalign_fault), 32'd1);
         check("mis_no_req", 32'(bus.imem_req_valid), 32'd0);
      end
      drive(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      @(negedge clk);
      check("mis_clear", 32'(bus.misalign_fault), 32'd0);
      check("mis_req_valid", 32'(bus.imem_req_valid), 32'd1);
      check("mis_req_addr", bus.imem_req_addr, 32'h0000_0200);
`else
      do_reset(10);
      drive(1'b0, 1'b1, 32'h0000_0102, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      @(negedge clk);
      check("align_fault", 32'(bus.misalign_fault), 32'd0);
      check("align_req_addr", bus.imem_req_addr, 32'h0000_0100);
`endif

      // Reset asserted with two requests outstanding; their responses arrive during reset.
      do_reset(10);
      min_delay = 3;
      max_delay = 3;
      repeat (2) drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
      @(negedge clk);
      check("rst_if_valid", 32'(bus.if_valid), 32'd0);
      check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      repeat (9) drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
      min_delay = 0;
      max_delay = 0;
      drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      @(negedge clk);
      check("rst_refetch_valid", 32'(bus.imem_req_valid), 32'd1);
      check("rst_refetch_addr", bus.imem_req_addr, RESET_PC);
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
         @(negedge clk);
         if (bus.if_valid) begin
            got = 1'b1;
            check("rst_if_pc", bus.if_pc, RESET_PC);
         end
      end
      check("rst_timeout", 32'(got), 32'd1);

      // Randomized traffic against the model.
      do_reset(10);
      min_delay = 0;
      max_delay = 3;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset(10);
         end else begin
            redir = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
               0:       rpc = 32'hFFFF_FFF8;
               1:       rpc = $urandom;
               default: rpc = 32'h0000_1000 + ($urandom & 32'h0000_0FFC);
            endcase
            drive(1'b0, redir, rpc, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7));
         end
      end
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, giving the number of instruction buffer entries; the legal value is 2 only.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1 bit: the rising-edge clock.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port imem_req_valid, output, 1 bit: a fetch request is presented.
REQ-007 SHALL have port imem_req_addr, output, 32 bits: the fetch word address.
REQ-008 SHALL have port imem_req_ready, input, 1 bit: memory accepts the request.
REQ-009 SHALL have port imem_rsp_valid, input, 1 bit: a response word is present.
REQ-010 SHALL have port imem_rsp_data, input, 32 bits: the instruction word.
REQ-011 SHALL have port redirect_valid, input, 1 bit: a branch, jump or trap redirect.
REQ-012 SHALL have port redirect_pc, input, 32 bits: the redirect target.
REQ-013 SHALL have port if_valid, output, 1 bit: an instruction is offered to decode and immediate generation.
REQ-014 SHALL have port if_instruction, output, 32 bits: the offered instruction.
REQ-015 SHALL have port if_pc, output, 32 bits: the PC of the offered instruction.
REQ-016 SHALL have port if_ready, input, 1 bit: decode accepts the offered instruction.
REQ-017 SHALL have port misalign_fault, output, 1 bit: a misaligned redirect was seen.

Function
REQ-018 SHALL treat a request as accepted in a cycle where imem_req_valid and imem_req_ready are both 1.
REQ-019 SHALL advance the fetch PC by 4 on each accepted request; the addition wraps modulo 2^32.
REQ-020 SHALL assume memory responses return in order, arriving one or more cycles after acceptance.
REQ-021 SHALL assert imem_req_valid only when outstanding requests plus buffered entries are fewer than 2, and no redirect or fault is active.
REQ-022 SHALL hold imem_req_addr stable while imem_req_valid is 1 and imem_req_ready is 0.
REQ-023 SHALL push each non-stale response into a 2-entry FIFO, storing the instruction together with its PC.
REQ-024 SHALL drive if_valid high whenever the FIFO is non-empty, with if_instruction and if_pc taken from the FIFO head.
REQ-025 SHALL pop the FIFO head when if_valid and if_ready are both 1.
REQ-026 SHALL allow a push and a pop in the same cycle, including when the FIFO is full.
REQ-027 SHALL, for a zero-wait path, give 2-cycle latency from request acceptance to if_valid.
REQ-028 SHALL, when redirect_valid is 1, in the same cycle:
- flush the FIFO;
- load the fetch PC with the redirect target;
- drive imem_req_valid to 0;
- load the drop counter with the number of outstanding requests.
REQ-029 SHALL issue the request to the redirect target in the cycle after the redirect.
REQ-030 SHALL discard any response that arrives while the drop counter is non-zero, and decrement the counter for each one discarded.
REQ-031 SHALL give redirect priority over a same-cycle request acceptance, response push or pop.
REQ-032 SHALL hold if_instruction and if_pc stable while if_valid is 1 and if_ready is 0.

Reset
REQ-033 SHALL, while rst is 1, set the fetch PC to RESET_PC and clear the FIFO, the outstanding count, the drop counter and misalign_fault.
REQ-034 SHALL drive imem_req_valid and if_valid to 0 while rst is 1.
REQ-035 SHALL issue the first request, to RESET_PC, in the first cycle after rst falls.
REQ-036 SHALL discard all in-flight data when rst is asserted mid-operation; responses to requests issued before reset are dropped.

Configuration
REQ-037 SHALL use the macro IF_MISALIGN_TRAP_EN to compile the misalignment trap in or out.
REQ-038 SHALL, when IF_MISALIGN_TRAP_EN is defined and a redirect has redirect_pc[1:0] != 0:
- set misalign_fault in the next cycle;
- keep it sticky until an aligned redirect or reset;
- issue no requests while it is set.
REQ-039 SHALL, when IF_MISALIGN_TRAP_EN is undefined, force redirect_pc[1:0] to 2'b00 and tie misalign_fault to 0.

Verification
REQ-040 SHALL cover reset release with zero-wait memory and if_ready=1: requests go to 0x0, 0x4 and 0x8, and if_valid first rises 2 cycles after the first acceptance with if_pc=0x0.
REQ-041 SHALL cover if_ready=0 for 5 cycles: the FIFO holds 2 entries (PC 0x0 and 0x4), imem_req_valid stays 0, and if_instruction stays stable.
REQ-042 SHALL cover a redirect to 0x100 with 1 request outstanding: that response is dropped, and the next if_pc is 0x100.
REQ-043 SHALL cover imem_req_ready=0 for 3 cycles: imem_req_addr is held at 0x8 and the PC does not advance.
REQ-044 SHALL cover, with the macro defined, a redirect to 0x102: misalign_fault is 1 on the next cycle and no requests follow; a later redirect to 0x200 clears it.
REQ-045 SHALL cover rst asserted mid-stream with 2 requests outstanding: if_valid is 0, late responses are ignored, and the refetch starts at RESET_PC.
